// File: rtl/scan_dig_pkg.sv
// Shared 7-segment glyph constants and the nibble-to-glyph lookup used by the digit scanner.
package scan_dig_pkg;

    localparam logic [7:0] SEG_0    = 8'h3F;
    localparam logic [7:0] SEG_1    = 8'h06;
    localparam logic [7:0] SEG_2    = 8'h5B;
    localparam logic [7:0] SEG_3    = 8'h4F;
    localparam logic [7:0] SEG_4    = 8'h66;
    localparam logic [7:0] SEG_5    = 8'h6D;
    localparam logic [7:0] SEG_6    = 8'h7D;
    localparam logic [7:0] SEG_7    = 8'h07;
    localparam logic [7:0] SEG_8    = 8'h7F;
    localparam logic [7:0] SEG_9    = 8'h6F;
    localparam logic [7:0] SEG_A    = 8'h77;
    localparam logic [7:0] SEG_B    = 8'h7C;
    localparam logic [7:0] SEG_C    = 8'h39;
    localparam logic [7:0] SEG_D    = 8'h5E;
    localparam logic [7:0] SEG_E    = 8'h79;
    localparam logic [7:0] SEG_DASH = 8'h40;
    // Nibble F shows a dash so the calendar path can use it as a separator.
    localparam logic [7:0] SEG_F    = SEG_DASH;
    localparam logic [7:0] SEG_OFF  = 8'h00;

    function automatic logic [7:0] seg7_glyph(input logic [3:0] nibble);
        logic [7:0] g;
        case (nibble)
            4'h0:    g = SEG_0;
            4'h1:    g = SEG_1;
            4'h2:    g = SEG_2;
            4'h3:    g = SEG_3;
            4'h4:    g = SEG_4;
            4'h5:    g = SEG_5;
            4'h6:    g = SEG_6;
            4'h7:    g = SEG_7;
            4'h8:    g = SEG_8;
            4'h9:    g = SEG_9;
            4'hA:    g = SEG_A;
            4'hB:    g = SEG_B;
            4'hC:    g = SEG_C;
            4'hD:    g = SEG_D;
            4'hE:    g = SEG_E;
            default: g = SEG_F;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/scan_dig_multi_seg7_decode.sv
// Combinational nibble + decimal point + dark flag to active-high {dp,g..a} pattern.
module seg7_decode
    import scan_dig_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       dark,
    output logic [7:0] pattern
);

    always_comb begin
        pattern = SEG_OFF;
        if (!dark) begin
            pattern = seg7_glyph(nibble) | {dp, 7'b0};
        end
    end

endmodule

// File: rtl/scan_dig_multi.sv
// Time-multiplexed NUM_DIG-digit 7-segment scanner with frame-synchronous shadowing, PWM and
// leading-zero suppression. Optional per-digit blinking when SCAN_DIG_BLINK_EN is defined.
module scan_dig_multi
    import scan_dig_pkg::*;
#(
    parameter int unsigned NUM_DIG     = 8,
    parameter int unsigned CLK_DIV     = 1000,
    parameter int unsigned BRIGHT_W    = 4,
    parameter bit          DIG_ACT_LOW = 1'b1,
    parameter bit          SEG_ACT_LOW = 1'b0
`ifdef SCAN_DIG_BLINK_EN
    ,
    parameter int unsigned BLINK_FRAMES = 256
`endif
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enable,
    input  logic [4*NUM_DIG-1:0]  data,
    input  logic [NUM_DIG-1:0]    dp,
    input  logic [NUM_DIG-1:0]    blank,
    input  logic                  lz_en,
    input  logic [BRIGHT_W-1:0]   bright,
`ifdef SCAN_DIG_BLINK_EN
    input  logic [NUM_DIG-1:0]    blink_mask,
`endif
    output logic [NUM_DIG-1:0]    dig,
    output logic [7:0]            seg,
    output logic                  frame_done
);

    localparam int unsigned PRE_W = $clog2(CLK_DIV);
    localparam int unsigned IDX_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIG - 1);
    localparam logic [NUM_DIG-1:0] DIG_OFF = DIG_ACT_LOW ? {NUM_DIG{1'b1}} : {NUM_DIG{1'b0}};
    localparam logic [7:0] SEG_UNLIT = SEG_ACT_LOW ? 8'hFF : 8'h00;

    logic [PRE_W-1:0]     pre_q, pre_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [BRIGHT_W-1:0]  pwm_q, pwm_d;
    logic                 first_q, first_d;
    logic [4*NUM_DIG-1:0] data_s_q, data_s_d;
    logic [NUM_DIG-1:0]   dp_s_q, dp_s_d, blank_s_q, blank_s_d;
    logic                 lz_s_q, lz_s_d;
    logic [NUM_DIG-1:0]   dig_q, dig_d;
    logic [7:0]           seg_q, seg_d;
    logic                 frame_done_q;
    logic                 tick, wrap, capture;

    logic [3:0]           nib [NUM_DIG];
    logic [NUM_DIG-1:0]   supp, blank_k, dp_k, dig_on, blink_k;
    logic                 dark_sel, lit, blink_off;
    logic [7:0]           pattern;

    always_comb begin
        tick    = enable && (pre_q == PRE_MAX);
        wrap    = tick && (idx_q == IDX_MAX);
        capture = wrap || (enable && first_q);
        first_d = first_q && !enable;

        pre_d = pre_q;
        if (enable) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
        end
        idx_d = idx_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end
        pwm_d = enable ? pwm_q + 1'b1 : pwm_q;

        data_s_d  = capture ? data  : data_s_q;
        dp_s_d    = capture ? dp    : dp_s_q;
        blank_s_d = capture ? blank : blank_s_q;
        lz_s_d    = capture ? lz_en : lz_s_q;
    end

`ifdef SCAN_DIG_BLINK_EN
    localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_FRAMES - 1);

    logic [BLK_W-1:0]   blk_cnt_q, blk_cnt_d;
    logic               phase_q, phase_d;
    logic [NUM_DIG-1:0] mask_s_q, mask_s_d;

    always_comb begin
        blk_cnt_d = blk_cnt_q;
        phase_d   = phase_q;
        mask_s_d  = capture ? blink_mask : mask_s_q;
        if (wrap) begin
            if (blk_cnt_q == BLK_MAX) begin
                blk_cnt_d = '0;
                phase_d   = !phase_q;
            end else begin
                blk_cnt_d = blk_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            blk_cnt_q <= '0;
            phase_q   <= 1'b1;
            mask_s_q  <= '0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
            phase_q   <= phase_d;
            mask_s_q  <= mask_s_d;
        end
    end

    assign blink_off = !phase_d;
    assign blink_k   = mask_s_d;
`else
    assign blink_off = 1'b0;
    assign blink_k   = '0;
`endif

    // Outputs are built from next-state values so dig/seg follow idx one clk after tick.
    always_comb begin
        logic prev;
        prev    = 1'b1;
        supp    = '0;
        blank_k = '0;
        dp_k    = '0;
        dig_on  = '0;
        for (int unsigned k = 0; k < NUM_DIG; k++) begin
            nib[k]     = data_s_d[4*(NUM_DIG-1-k) +: 4];
            blank_k[k] = blank_s_d[NUM_DIG-1-k];
            dp_k[k]    = dp_s_d[NUM_DIG-1-k];
            supp[k]    = (k != NUM_DIG - 1) && lz_s_d && (nib[k] == 4'h0) && prev;
            prev       = supp[k];
            dig_on[NUM_DIG-1-k] = (idx_d == IDX_W'(k));
        end
        dark_sel = blank_k[idx_d] || supp[idx_d] || (blink_off && blink_k[idx_d]);
        lit      = (bright == '1) || (pwm_d < bright);
    end

    seg7_decode u_decode (
        .nibble  (nib[idx_d]),
        .dp      (dp_k[idx_d]),
        .dark    (dark_sel),
        .pattern (pattern)
    );

    always_comb begin
        dig_d = DIG_OFF;
        seg_d = SEG_UNLIT;
        if (enable && lit) begin
            dig_d = DIG_ACT_LOW ? ~dig_on : dig_on;
            seg_d = SEG_ACT_LOW ? ~pattern : pattern;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pre_q        <= '0;
            idx_q        <= '0;
            pwm_q        <= '0;
            first_q      <= 1'b1;
            data_s_q     <= '0;
            dp_s_q       <= '0;
            blank_s_q    <= '0;
            lz_s_q       <= 1'b0;
            dig_q        <= DIG_OFF;
            seg_q        <= SEG_UNLIT;
            frame_done_q <= 1'b0;
        end else begin
            pre_q        <= pre_d;
            idx_q        <= idx_d;
            pwm_q        <= pwm_d;
            first_q      <= first_d;
            data_s_q     <= data_s_d;
            dp_s_q       <= dp_s_d;
            blank_s_q    <= blank_s_d;
            lz_s_q       <= lz_s_d;
            dig_q        <= dig_d;
            seg_q        <= seg_d;
            frame_done_q <= wrap;
        end
    end

    assign dig        = dig_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;

endmodule
